// File: rtl/taxi_disp_pkg.sv
// Shared constants for the taxi wait-duration display: segment patterns and
// converter state encoding.
package taxi_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } conv_state_e;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_DASH;
        end
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: samples value in IDLE, spends DW cycles
// shifting, then latches NDIG BCD digits and pulses done.
module bin2bcd_seq
    import taxi_disp_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NDIG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DW-1:0]     value,
    output logic [4*NDIG-1:0] bcd,
    output logic              done,
    output logic              sample,
    output logic              load
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    conv_state_e   state;
    logic [DW-1:0] sh;
    logic [BW-1:0] work;
    logic [BW-1:0] adj;
    logic [CW-1:0] bit_cnt;

    // Add-3 correction on every work digit before the shift
    always_comb begin
        adj = work;
        for (int unsigned d = 0; d < NDIG; d++) begin
            if (work[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            work    <= '0;
            bit_cnt <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh      <= value;
                        work    <= '0;
                        bit_cnt <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // Digits shifted out past NDIG are dropped; the top flags overflow
                    {work, sh} <= {adj[BW-2:0], sh, 1'b0};
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DW - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= work;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sample = (state == IDLE) && start;
    assign load   = (state == DONE);

endmodule

// File: rtl/wait_seg_display.sv
// Wait-duration display: free-running binary-to-BCD conversion feeding a
// multiplexed common-anode 7-segment scan with leading-zero blanking.
module wait_seg_display
    import taxi_disp_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned NDIG      = 8,
    parameter int unsigned MAX_SHOWN = 99_999_999,
    parameter int unsigned CNT_SCAN  = 50_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [DW-1:0]   value,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            conv_done
);

    localparam int unsigned   BW      = 4 * NDIG;
    localparam int unsigned   IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned   SW      = (CNT_SCAN > 1) ? $clog2(CNT_SCAN) : 1;
    localparam logic [DW-1:0] MAX_VAL = DW'(MAX_SHOWN);

    logic [BW-1:0]   bcd;
    logic            done;
    logic            sample;
    logic            load;
    logic            ovf_next;
    logic            ovf;
    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   msd;
    logic [3:0]      digit;
    logic [6:0]      seg_d;
    logic [NDIG-1:0] an_d;

    bin2bcd_seq #(
        .DW   (DW),
        .NDIG (NDIG)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (1'b1),
        .value  (value),
        .bcd    (bcd),
        .done   (done),
        .sample (sample),
        .load   (load)
    );

    assign conv_done = done;

    // Overflow flag travels alongside the conversion so it lands with its BCD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_next <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (sample) begin
                ovf_next <= (value > MAX_VAL);
            end
            if (load) begin
                ovf <= ovf_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(CNT_SCAN - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Most significant non-zero digit; everything above it is blanked
    always_comb begin
        msd = '0;
        for (int unsigned d = 1; d < NDIG; d++) begin
            if (bcd[4*d +: 4] != 4'd0) begin
                msd = IW'(d);
            end
        end
    end

    assign digit = bcd[{idx, 2'b00} +: 4];

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (enable) begin
            an_d = ~(NDIG'(1) << idx);
            if (ovf) begin
                seg_d = SEG_DASH;
            end else if (idx > msd) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_of(digit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_wait_seg_display.sv
// Self-checking bench for wait_seg_display with a fast scan (CNT_SCAN=4).
module tb_wait_seg_display;

    localparam int DW    = 32;
    localparam int NDIG  = 8;
    localparam int SCAN  = 4;
    localparam int PER   = DW + 2;
    localparam int FRAME = NDIG * SCAN;

    typedef struct {
        logic [31:0]     value;
        logic [7:0][6:0] segs;
        string           name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] value;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        conv_done;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int last_done;
    bit have_done = 0;

    logic [6:0] lut [10];

    wait_seg_display #(
        .DW        (DW),
        .NDIG      (NDIG),
        .MAX_SHOWN (99_999_999),
        .CNT_SCAN  (SCAN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .value     (value),
        .seg       (seg),
        .an        (an),
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string msg);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s", msg);
    endtask

    // conv_done must arrive exactly once every DW+2 cycles while out of reset
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_done = 0;
        end else if (conv_done) begin
            if (have_done)
                check(cyc - last_done == PER,
                      $sformatf("cadence: gap %0d cycles, expected %0d", cyc - last_done, PER));
            last_done = cyc;
            have_done = 1;
        end
    end

    // Decimal reference: what each digit should show for value v
    function automatic logic [7:0][6:0] model_segs(input longint unsigned v);
        logic [7:0][6:0] r;
        longint unsigned p;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (v > 64'd99_999_999) r[i] = 7'h3F;
            else if (i > 0 && v < p) r[i] = 7'h7F;
            else r[i] = lut[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic wait_done(output int n, input string name);
        n = 0;
        for (int k = 1; k <= PER + 6; k++) begin
            @(negedge clk);
            if (conv_done) begin
                n = k;
                break;
            end
        end
        if (n == 0) check(1'b0, $sformatf("%s: conv_done timeout", name));
    endtask

    // One full scan frame: every cycle one digit lit with the right pattern,
    // the index stepping +1 mod NDIG, each digit held SCAN cycles
    task automatic check_scan(input logic [7:0][6:0] exp, input string name);
        int hits [8];
        int prev;
        int zeros;
        int idx;
        bit ok;
        prev = -1;
        for (int i = 0; i < NDIG; i++) hits[i] = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            zeros = 0;
            idx   = 0;
            for (int b = 0; b < NDIG; b++) begin
                if (!an[b]) begin
                    zeros++;
                    idx = b;
                end
            end
            ok = (zeros == 1) && (seg == exp[idx]) &&
                 (prev < 0 || idx == prev || idx == (prev + 1) % NDIG);
            check(ok, $sformatf("%s cycle %0d: an=%h seg=%h, expected seg=%h on digit %0d",
                                name, c, an, seg, exp[idx], idx));
            if (zeros == 1) hits[idx]++;
            prev = idx;
        end
        for (int i = 0; i < NDIG; i++)
            check(hits[i] == SCAN, $sformatf("%s dwell digit %0d: %0d cycles, expected %0d",
                                             name, i, hits[i], SCAN));
    endtask

    task automatic apply(input logic [31:0] v, input logic [7:0][6:0] exp, input string name);
        int n;
        value = v;
        wait_done(n, name);
        wait_done(n, name);
        check_scan(exp, name);
    endtask

    initial begin
        vec_t            tbl [7];
        logic [7:0][6:0] zero_segs;
        logic [7:0][6:0] e;
        logic [31:0]     rv;
        logic [7:0]      prev_an;
        int              n;
        int              i0;

        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        zero_segs = {{7{7'h7F}}, 7'h40};

        tbl[0] = '{32'd1234,        {{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}, "v1234"};
        tbl[1] = '{32'd0,           {{7{7'h7F}}, 7'h40},                       "v0"};
        tbl[2] = '{32'd99_999_999,  {8{7'h10}},                                "vmax"};
        tbl[3] = '{32'd100_000_000, {8{7'h3F}},                                "vmax_plus1"};
        tbl[4] = '{32'hFFFF_FFFF,   {8{7'h3F}},                                "vall_ones"};
        tbl[5] = '{32'd5,           {{7{7'h7F}}, 7'h12},                       "v5_after_ovf"};
        tbl[6] = '{32'd10,          {{6{7'h7F}}, 7'h79, 7'h40},                "v10"};

        // Reset state and first conversion latency
        rst_n  = 1'b0;
        enable = 1'b1;
        value  = 32'd1234;
        repeat (3) @(negedge clk);
        check(seg == 7'h7F, $sformatf("reset seg: got %h, expected 7f", seg));
        check(an == 8'hFF, $sformatf("reset an: got %h, expected ff", an));
        check(conv_done == 1'b0, $sformatf("reset conv_done: got %b, expected 0", conv_done));
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done(n, "first_latency");
        check(n == PER, $sformatf("first_latency: conv_done after %0d cycles, expected %0d", n, PER));

        for (int t = 0; t < 7; t++) apply(tbl[t].value, tbl[t].segs, tbl[t].name);

        // Reset in the middle of a conversion
        value = 32'd1234;
        wait_done(n, "midconv");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(seg == 7'h7F, $sformatf("midconv reset seg: got %h, expected 7f", seg));
        check(an == 8'hFF, $sformatf("midconv reset an: got %h, expected ff", an));
        @(negedge clk);
        #2 rst_n = 1'b1;
        check_scan(zero_segs, "restart_zero");
        wait_done(n, "restart_latency");
        check(n == PER - FRAME,
              $sformatf("restart_latency: conv_done %0d cycles after frame, expected %0d",
                        n, PER - FRAME));
        check_scan(tbl[0].segs, "restart_1234");

        // Only the IDLE sample counts
        value = 32'd42;
        wait_done(n, "hold42");
        repeat (2) @(negedge clk);
        value = 32'd77;
        wait_done(n, "hold42");
        check_scan(model_segs(42), "hold42");
        wait_done(n, "then77");
        check_scan(model_segs(77), "then77");

        // Blank the display mid-scan; scan keeps running underneath
        e = model_segs(77);
        prev_an = an;
        i0 = -1;
        for (int k = 0; k < 2 * SCAN; k++) begin
            @(negedge clk);
            if (an != prev_an) begin
                for (int b = 0; b < NDIG; b++) if (!an[b]) i0 = b;
                break;
            end
            prev_an = an;
        end
        check(i0 >= 0, "enable: no digit transition seen");
        if (i0 < 0) i0 = 0;
        enable = 1'b0;
        for (int k = 0; k < 2 * SCAN - 1; k++) begin
            @(negedge clk);
            check(an == 8'hFF && seg == 7'h7F,
                  $sformatf("disabled cycle %0d: an=%h seg=%h, expected ff/7f", k, an, seg));
        end
        enable = 1'b1;
        @(negedge clk);
        check(an == ~(8'h01 << ((i0 + 2) % NDIG)) && seg == e[(i0 + 2) % NDIG],
              $sformatf("resume: an=%h seg=%h, expected digit %0d seg=%h",
                        an, seg, (i0 + 2) % NDIG, e[(i0 + 2) % NDIG]));
        check_scan(e, "after_resume");

        // Random values against the decimal reference
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 2))
                0: rv = $urandom;
                1: rv = $urandom_range(0, 99_999_999);
                default: rv = $urandom_range(0, 999);
            endcase
            apply(rv, model_segs(rv), $sformatf("rand%0d_v%0d", r, rv));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
